// File: rtl/bin_morph_pkg.sv
// Shared types and helpers for the binary 3x3 morphology stage.
package bin_morph_pkg;

  localparam int MODE_ERODE  = 0;
  localparam int MODE_DILATE = 1;

  // 3x3 binary window, bit index = row*3 + col (row 0 = top, col 2 = newest)
  typedef logic [8:0] win_t;

  // Counter width for values 0..n-1, never below one bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/win3x3_reg.sv
// Clock-enabled 3-column shift window plus the position tag of the column
// that entered it. vld marks a cycle in which a new column was shifted in.
module win3x3_reg
  import bin_morph_pkg::*;
#(
  parameter int COL_W = 3,
  parameter int ROW_W = 3
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             clken,
  input  logic [2:0]       col_new,   // {top, middle, bottom}
  input  logic [COL_W-1:0] pos_col,
  input  logic [ROW_W-1:0] pos_row,
  output win_t             win,
  output logic             vld,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row
);

  win_t win_nxt;

  // Shift every row one column left and drop the new column in at col 2
  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < 3; r++) begin
      win_nxt[r*3 + 0] = win[r*3 + 1];
      win_nxt[r*3 + 1] = win[r*3 + 2];
      win_nxt[r*3 + 2] = col_new[2 - r];
    end
  end

  // Window and tag only move on a pixel enable; vld tracks the enable
  always_ff @(posedge clk) begin
    if (Reset) begin
      win <= '0;
      vld <= 1'b0;
      col <= '0;
      row <= '0;
    end else begin
      vld <= clken;
      if (clken) begin
        win <= win_nxt;
        col <= pos_col;
        row <= pos_row;
      end
    end
  end

endmodule

// File: rtl/bin_morph_3x3.sv
// Binary 3x3 erosion/dilation over a streamed image fed by a two-tap row
// buffer. Emits center-tagged pixels with border masking.
// Optional foreground counter on fg_count: define BIN_MORPH_STATS_EN.
module bin_morph_3x3
  import bin_morph_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MODE       = MODE_ERODE,
  parameter bit BORDER_VAL = 1'b0,
  localparam int COL_W = cnt_w(IMG_WIDTH),
  localparam int ROW_W = cnt_w(IMG_HEIGHT),
  localparam int CNT_W = cnt_w(IMG_WIDTH * IMG_HEIGHT) + 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             clken,
  input  logic             frame_start,
  input  logic             row0,
  input  logic             row1,
  input  logic             row2,
  output logic             pix_out,
  output logic             pix_valid,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             frame_done,
  output logic [CNT_W-1:0] fg_count
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] in_col, samp_col, s1_col;
  logic [ROW_W-1:0] in_row, samp_row, s1_row;
  logic             s1_vld;
  win_t             win;

  // frame_start pins the sampled pixel to (0,0) regardless of the counters
  assign samp_col = frame_start ? '0 : in_col;
  assign samp_row = frame_start ? '0 : in_row;

  // Raster position of the next input pixel, advancing on pixel enable
  always_ff @(posedge clk) begin
    if (Reset) begin
      in_col <= '0;
      in_row <= '0;
    end else if (clken) begin
      if (samp_col == LAST_COL) begin
        in_col <= '0;
        in_row <= (samp_row == LAST_ROW) ? '0 : samp_row + ROW_W'(1);
      end else begin
        in_col <= samp_col + COL_W'(1);
        in_row <= samp_row;
      end
    end
  end

  win3x3_reg #(.COL_W(COL_W), .ROW_W(ROW_W)) u_win (
    .clk     (clk),
    .Reset   (Reset),
    .clken   (clken),
    .col_new ({row2, row1, row0}),
    .pos_col (samp_col),
    .pos_row (samp_row),
    .win     (win),
    .vld     (s1_vld),
    .col     (s1_col),
    .row     (s1_row)
  );

  // The window is centred one row up and one column left of the newest pixel.
  // Until two full columns/rows have entered, part of the window is stale
  // (previous line or previous frame), so those centres get BORDER_VAL.
  logic has_ctr, full, morph;
  assign has_ctr = (s1_row != '0) && (s1_col != '0);
  assign full    = (s1_row >= ROW_W'(2)) && (s1_col >= COL_W'(2));
  assign morph   = (MODE == MODE_DILATE) ? (|win) : (&win);

  // Output register: one strobe per enabled input that has a valid centre
  always_ff @(posedge clk) begin
    if (Reset) begin
      pix_out    <= 1'b0;
      pix_valid  <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= s1_vld && has_ctr;
      pix_out    <= (s1_vld && has_ctr) ? (full ? morph : BORDER_VAL) : 1'b0;
      out_col    <= s1_col - COL_W'(1);
      out_row    <= s1_row - ROW_W'(1);
      frame_done <= s1_vld && (s1_row == LAST_ROW) && (s1_col == LAST_COL);
    end
  end

`ifdef BIN_MORPH_STATS_EN
  logic [CNT_W-1:0] acc;

  // Running foreground sum; snapshot into fg_count on the frame's last pixel
  always_ff @(posedge clk) begin
    if (Reset) begin
      acc      <= '0;
      fg_count <= '0;
    end else if (pix_valid) begin
      if (frame_done) begin
        fg_count <= acc + CNT_W'(pix_out);
        acc      <= '0;
      end else begin
        acc <= acc + CNT_W'(pix_out);
      end
    end
  end
`else
  assign fg_count = '0;
`endif

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Self-checking bench: erosion and dilation instances share one input
// stream; outputs are captured and compared against a window model.
module tb_bin_morph_3x3;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst, clken, frame_start, row0, row1, row2;
  logic       pe, ve, fde, pd, vd, fdd;
  logic [2:0] ce_col, cd_col, ce_row, cd_row;
  logic [6:0] fge, fgd;

  always #5 clk = ~clk;

  bin_morph_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MODE(0), .BORDER_VAL(1'b0)) dut_e (
    .clk(clk), .Reset(rst), .clken(clken), .frame_start(frame_start),
    .row0(row0), .row1(row1), .row2(row2),
    .pix_out(pe), .pix_valid(ve), .out_col(ce_col), .out_row(ce_row),
    .frame_done(fde), .fg_count(fge));

  bin_morph_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MODE(1), .BORDER_VAL(1'b0)) dut_d (
    .clk(clk), .Reset(rst), .clken(clken), .frame_start(frame_start),
    .row0(row0), .row1(row1), .row2(row2),
    .pix_out(pd), .pix_valid(vd), .out_col(cd_col), .out_row(cd_row),
    .frame_done(fdd), .fg_count(fgd));

  // {pix, row, col, done}
  typedef logic [7:0] ev_t;

  ev_t cap[2][$];
  ev_t expq[2][$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  viol = 0;
  bit  last_ce = 1'b1;
  bit  img[H][W];

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic int ones(input int k);
    int n = 0;
    foreach (expq[k][i]) n += int'(expq[k][i][7]);
    return n;
  endfunction

  function automatic int fg_want(input int k);
`ifdef BIN_MORPH_STATS_EN
    return ones(k);
`else
    return 0 * k;
`endif
  endfunction

  // One clock: drive inputs, then sample outputs 1 time unit after the edge
  task automatic step(input bit ce, input bit fs, input bit rs,
                      input bit r0, input bit r1, input bit r2);
    clken = ce; frame_start = fs; rst = rs; row0 = r0; row1 = r1; row2 = r2;
    @(posedge clk); #1;
    if (!rs) begin
      if (ve) cap[0].push_back({pe, ce_row, ce_col, fde});
      if (vd) cap[1].push_back({pd, cd_row, cd_col, fdd});
      if (!last_ce && (ve || vd)) viol++;
    end
    last_ce = ce;
  endtask

  // Stream npix pixels of img in raster order; rows above the image get junk.
  // gaps: 0 none, 1 idle cycle after every pixel, 2 random idle cycles.
  task automatic stream_frame(input int gaps, input int npix);
    for (int p = 0; p < npix; p++) begin
      int r = p / W;
      int c = p % W;
      step(1'b1, p == 0, 1'b0, img[r][c],
           (r >= 1) ? img[r-1][c] : rb(),
           (r >= 2) ? img[r-2][c] : rb());
      if (gaps == 1 || (gaps == 2 && rb()))
        step(1'b0, rb(), 1'b0, rb(), rb(), rb());
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_caps();
    cap[0].delete(); cap[1].delete(); viol = 0;
  endtask

  // Reference: every input (r,c) with r,c >= 1 emits centre (r-1,c-1);
  // the value is the AND/OR of the 3x3 image block when r,c >= 2, else 0.
  task automatic build_exp();
    expq[0].delete(); expq[1].delete();
    for (int r = 1; r < H; r++)
      for (int c = 1; c < W; c++) begin
        bit a = 1'b0, o = 1'b0;
        bit dn = (r == H-1) && (c == W-1);
        if (r >= 2 && c >= 2) begin
          a = 1'b1;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
              a = a & img[r-2+dr][c-2+dc];
              o = o | img[r-2+dr][c-2+dc];
            end
        end
        expq[0].push_back({a, 3'(r-1), 3'(c-1), dn});
        expq[1].push_back({o, 3'(r-1), 3'(c-1), dn});
      end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (kind == 1) ? 1'b1 : (kind == 2) ? rb() : 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({ve, pe, ce_row, ce_col, fde} !== 9'd0) begin
      n_bad++; $display("FAIL reset_out_e got %b want 0", {ve, pe, ce_row, ce_col, fde});
    end
    n_cmp++;
    if ({vd, pd, cd_row, cd_col, fdd} !== 9'd0) begin
      n_bad++; $display("FAIL reset_out_d got %b want 0", {vd, pd, cd_row, cd_col, fdd});
    end
    n_cmp++;
    if (fge !== 7'd0 || fgd !== 7'd0) begin
      n_bad++; $display("FAIL reset_fg got %0d/%0d want 0", fge, fgd);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ve !== 1'b0 || vd !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got %b%b want 00", ve, vd);
    end
  endtask

  task automatic test_all_ones();
    int bad_border = 0;
    fill(1); build_exp(); clear_caps();
    stream_frame(0, W*H); flush();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (cap[k].size() != expq[k].size()) begin
        n_bad++; $display("FAIL ones_len dut%0d got %0d want %0d", k, cap[k].size(), expq[k].size());
      end
      for (int i = 0; i < cap[k].size() && i < expq[k].size(); i++) begin
        n_cmp++;
        if (cap[k][i] !== expq[k][i]) begin
          n_bad++; $display("FAIL ones_ev dut%0d #%0d got %h want %h", k, i, cap[k][i], expq[k][i]);
        end
      end
    end
    n_cmp++;
    if (cap[0].size() != 35) begin
      n_bad++; $display("FAIL ones_strobes got %0d want 35", cap[0].size());
    end
    foreach (cap[0][i])
      if ((cap[0][i][6:4] == 3'd0 || cap[0][i][3:1] == 3'd0) && cap[0][i][7]) bad_border++;
    n_cmp++;
    if (bad_border != 0) begin
      n_bad++; $display("FAIL ones_border got %0d ones want 0", bad_border);
    end
    n_cmp++;
    if (cap[0].size() == 0 || cap[0][cap[0].size()-1] !== 8'b1_100_110_1) begin
      n_bad++; $display("FAIL ones_last got %h want %h",
                        (cap[0].size() == 0) ? 8'h00 : cap[0][cap[0].size()-1], 8'b1_100_110_1);
    end
    n_cmp++;
    if (int'(fge) != fg_want(0)) begin
      n_bad++; $display("FAIL ones_fg got %0d want %0d", fge, fg_want(0));
    end
  endtask

  task automatic test_single_dot();
    int on_e = 0, on_d = 0;
    fill(0); img[3][3] = 1'b1; build_exp(); clear_caps();
    stream_frame(0, W*H); flush();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (cap[k].size() != expq[k].size()) begin
        n_bad++; $display("FAIL dot_len dut%0d got %0d want %0d", k, cap[k].size(), expq[k].size());
      end
      for (int i = 0; i < cap[k].size() && i < expq[k].size(); i++) begin
        n_cmp++;
        if (cap[k][i] !== expq[k][i]) begin
          n_bad++; $display("FAIL dot_ev dut%0d #%0d got %h want %h", k, i, cap[k][i], expq[k][i]);
        end
      end
    end
    foreach (cap[0][i]) on_e += int'(cap[0][i][7]);
    foreach (cap[1][i]) on_d += int'(cap[1][i][7]);
    n_cmp++;
    if (on_e != 0 || on_d != 9) begin
      n_bad++; $display("FAIL dot_ones got %0d/%0d want 0/9", on_e, on_d);
    end
  endtask

  task automatic test_clken_toggle();
    fill(1); build_exp(); clear_caps();
    stream_frame(1, W*H); flush();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (cap[k].size() != expq[k].size()) begin
        n_bad++; $display("FAIL tog_len dut%0d got %0d want %0d", k, cap[k].size(), expq[k].size());
      end
      for (int i = 0; i < cap[k].size() && i < expq[k].size(); i++) begin
        n_cmp++;
        if (cap[k][i] !== expq[k][i]) begin
          n_bad++; $display("FAIL tog_ev dut%0d #%0d got %h want %h", k, i, cap[k][i], expq[k][i]);
        end
      end
    end
    n_cmp++;
    if (viol != 0) begin
      n_bad++; $display("FAIL tog_valid_after_idle got %0d want 0", viol);
    end
  endtask

  task automatic test_reset_mid();
    fill(2); build_exp(); clear_caps();
    stream_frame(0, 3*W + 5);
    step(1'b1, 1'b0, 1'b1, img[3][5], img[2][5], img[1][5]);
    n_cmp++;
    if ({ve, pe, ce_row, ce_col, fde, vd, pd} !== 11'd0) begin
      n_bad++; $display("FAIL rstmid_out got %b want 0", {ve, pe, ce_row, ce_col, fde, vd, pd});
    end
    n_cmp++;
    if (fge !== 7'd0) begin
      n_bad++; $display("FAIL rstmid_fg got %0d want 0", fge);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ve !== 1'b0 || vd !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_pending got %b%b want 00", ve, vd);
    end
    clear_caps();
    stream_frame(0, W*H); flush();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (cap[k].size() != expq[k].size()) begin
        n_bad++; $display("FAIL rstmid_len dut%0d got %0d want %0d", k, cap[k].size(), expq[k].size());
      end
      for (int i = 0; i < cap[k].size() && i < expq[k].size(); i++) begin
        n_cmp++;
        if (cap[k][i] !== expq[k][i]) begin
          n_bad++; $display("FAIL rstmid_ev dut%0d #%0d got %h want %h", k, i, cap[k][i], expq[k][i]);
        end
      end
    end
    n_cmp++;
    if (int'(fgd) != fg_want(1)) begin
      n_bad++; $display("FAIL rstmid_fg_d got %0d want %0d", fgd, fg_want(1));
    end
  endtask

  // Abandon a partial frame, then restart with frame_start (no reset)
  task automatic test_random_restart();
    for (int f = 0; f < 3; f++) begin
      fill(2);
      stream_frame(2, 10 + int'($urandom_range(0, 25)));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(2); build_exp(); clear_caps();
      stream_frame(2, W*H); flush();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (cap[k].size() != expq[k].size()) begin
          n_bad++; $display("FAIL rand_len f%0d dut%0d got %0d want %0d", f, k, cap[k].size(), expq[k].size());
        end
        for (int i = 0; i < cap[k].size() && i < expq[k].size(); i++) begin
          n_cmp++;
          if (cap[k][i] !== expq[k][i]) begin
            n_bad++; $display("FAIL rand_ev f%0d dut%0d #%0d got %h want %h", f, k, i, cap[k][i], expq[k][i]);
          end
        end
      end
      n_cmp++;
      if (int'(fge) != fg_want(0) || int'(fgd) != fg_want(1)) begin
        n_bad++; $display("FAIL rand_fg f%0d got %0d/%0d want %0d/%0d", f, fge, fgd, fg_want(0), fg_want(1));
      end
      n_cmp++;
      if (viol != 0) begin
        n_bad++; $display("FAIL rand_valid_after_idle f%0d got %0d want 0", f, viol);
      end
    end
  endtask

  task automatic test_stats();
    fill(1); build_exp(); clear_caps();
    stream_frame(0, W*H); flush();
    n_cmp++;
    if (int'(fge) != fg_want(0) || fg_want(0) != ((`ifdef BIN_MORPH_STATS_EN 24 `else 0 `endif))) begin
      n_bad++; $display("FAIL stats_ones got %0d want %0d", fge, fg_want(0));
    end
    fill(0); build_exp(); clear_caps();
    stream_frame(0, W*H); flush();
    n_cmp++;
    if (fge !== 7'd0 || fgd !== 7'd0) begin
      n_bad++; $display("FAIL stats_zeros got %0d/%0d want 0", fge, fgd);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_dot();
    test_clken_toggle();
    test_reset_mid();
    test_random_restart();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_morph_3x3.md
Name: bin_morph_3x3

Overview:
- Binary 3x3 morphology stage fed directly by the two-tap row shift buffer.
- Consumes the current-row pixel plus the one-row-up and two-rows-up taps on every pixel-enable cycle.
- Builds a 3x3 window and emits eroded or dilated pixels with position tags and border masking.
- Output feeds the downstream binary-image consumer (labelling/display).

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)
- MODE, 0, 0 = erosion (AND of 9), 1 = dilation (OR of 9)
- BORDER_VAL, 0, value forced at window-incomplete positions

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- clken  in  1  pixel enable; all inputs below are sampled only when high
- frame_start  in  1  marks the first pixel (col 0, row 0) of a frame
- row0  in  1  current-row pixel (shift-buffer input)
- row1  in  1  one-row-up pixel (tap 0)
- row2  in  1  two-rows-up pixel (tap 1)
- pix_out  out  1  morphology result
- pix_valid  out  1  one-cycle strobe qualifying pix_out
- out_col  out  clog2(IMG_WIDTH)  center column of the emitted pixel
- out_row  out  clog2(IMG_HEIGHT)  center row of the emitted pixel
- frame_done  out  1  pulses with the last emitted pixel of a frame
- fg_count  out  clog2(IMG_WIDTH*IMG_HEIGHT)+1  foreground count (optional feature)

Behaviour:
- Reset:
  - All outputs are 0; in_col and in_row are 0; the window is cleared to 0.
  - Reset has priority over clken and frame_start.
- Input position counters in_col/in_row:
  - Advance on clken only. in_col wraps at IMG_WIDTH-1 and then increments in_row.
  - in_row wraps at IMG_HEIGHT-1 to 0.
  - frame_start with clken forces the sampled pixel to position (0,0); the counters then continue from (1,0).
  - frame_start without clken is ignored.
- Stage 1 (on clken):
  - Window shifts left by one column; new right column = {row2, row1, row0}, top to bottom.
  - The position of the sampled pixel is registered with the window.
- Stage 2 (one clk after stage 1, independent of clken):
  - Register pix_out, pix_valid, out_col, out_row and frame_done.
  - Latency: input sampled at edge E -> outputs valid after edge E+1.
  - Back-to-back clken gives one output per clk.
- Emission and masking:
  - Center = (in_row-1, in_col-1).
  - pix_valid = 1 only if in_row>=1 and in_col>=1.
  - pix_out = MODE result if in_row>=2 and in_col>=2; otherwise BORDER_VAL.
  - Emitted frame covers centers rows 0..IMG_HEIGHT-2 and cols 0..IMG_WIDTH-2.
  - The last center row and column are never emitted. This is intentional: the line buffer provides no lookahead.
- Stale window data:
  - At in_col 0 and 1, the window's left columns hold the previous line's data.
  - The border rule masks this data; it must never reach pix_out.
- frame_done: asserted with pix_valid when in_row=IMG_HEIGHT-1 and in_col=IMG_WIDTH-1.
- clken low: the window and counters hold; pix_valid is 0 on the following cycle.
- Reset mid-frame:
  - Clears state and drops any pending stage-2 output.
  - The next emitted pixels follow the counter values from (0,0).

Optional Feature:
- Macro BIN_MORPH_STATS_EN.
- When defined:
  - An internal counter adds pix_out on each pix_valid.
  - On frame_done, fg_count latches the total including that pixel, and the counter clears.
  - fg_count holds until the next frame_done; Reset clears it.
- When undefined: the port exists but is tied to 0, and no counter logic is built.

Decomposition:
- Package bin_morph_pkg:
  - MODE_ERODE=0, MODE_DILATE=1.
  - Width helper function for counter widths (clog2).
  - 3x3 window typedef (9-bit packed, index = row*3+col).
- Sub-module win3x3_reg: the clken-gated 3-column shift window with its registered position tag.
- Counters, masking, the morphology reduce and the stats counter stay in bin_morph_3x3.

Test Plan:
- Settings for all scenarios: IMG_WIDTH=8, IMG_HEIGHT=6, continuous clken.
- Reset then an all-ones frame, MODE=0:
  - 35 pix_valid strobes.
  - pix_out=0 at out_row 0 or out_col 0; pix_out=1 at the 24 interior centers.
  - frame_done with the 35th strobe, at out (4,6).
- Single 1 at (3,3), MODE=1: pix_out=1 exactly at the centers (2..4, 2..4) excluding border; all others 0.
- Same image, MODE=0: every pix_out=0.
- clken toggling 1-0-1 over an all-ones frame:
  - Output sequence is identical to the continuous case.
  - pix_valid never asserts in the cycle after a clken-low cycle.
- Reset asserted mid-frame at in (3,5), then frame_start: outputs clear next cycle; the restarted frame matches the reference sequence exactly.
- BIN_MORPH_STATS_EN, all-ones frame, MODE=0: fg_count=24 after frame_done; a second all-zeros frame gives fg_count=0.
